// File: rtl/regfile_mp_pkg.sv
// Shared defaults, read-source encoding and read-port packing helper for the
// multi-port register file with reservation scoreboard.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic [1:0] {
    RD_STORE = 2'd0,
    RD_BYP0  = 2'd1,
    RD_BYP1  = 2'd2,
    RD_ZERO  = 2'd3
  } rd_src_e;

  // Bit offset of read port 'port' inside a packed bus of 'width'-bit lanes.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Reservation scoreboard: one busy bit per register, set by accepted
// reservations and cleared by writes; drives resv_rdy and per-port read_busy.
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_add,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_add,
  input  logic                     resv_vld,
  input  logic [ADDR_W-1:0]        resv_add,
  input  logic [NUM_RD*ADDR_W-1:0] read_add,
  output logic                     resv_rdy,
  output logic [NUM_RD-1:0]        read_busy,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              resv_zero;
  logic              resv_wr_hit;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];

  always_comb begin
    resv_zero   = ZERO_R0 && (resv_add == '0);
    resv_wr_hit = (wr0_en && (wr0_add == resv_add)) ||
                  (wr1_en && (wr1_add == resv_add));
    // A write landing this cycle frees the register, so the request may proceed.
    resv_rdy    = rst_n && resv_vld &&
                  (resv_zero || !busy_q[resv_add] || resv_wr_hit);
  end

  always_comb begin
    busy_d = busy_q;
    if (wr0_en) busy_d[wr0_add] = 1'b0;
    if (wr1_en) busy_d[wr1_add] = 1'b0;
    if (resv_rdy && !resv_zero) busy_d[resv_add] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    read_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k]   = read_add[port_lsb(k, ADDR_W) +: ADDR_W];
      read_busy[k] = busy_q[rd_addr[k]] &&
                     !((wr0_en && (wr0_add == rd_addr[k])) ||
                       (wr1_en && (wr1_add == rd_addr[k])));
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with combinational write bypass and an
// optional hard-wired zero register; reservation tracking lives in regfile_sb.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     writ_ena0,
  input  logic [ADDR_W-1:0]        writ_add0,
  input  logic [DATA_W-1:0]        writ_dat0,
  input  logic                     writ_ena1,
  input  logic [ADDR_W-1:0]        writ_add1,
  input  logic [DATA_W-1:0]        writ_dat1,
  input  logic [NUM_RD*ADDR_W-1:0] read_add,
  output logic [NUM_RD*DATA_W-1:0] read_dat,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     resv_vld,
  input  logic [ADDR_W-1:0]        resv_add,
  output logic                     resv_rdy,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr0_en;
  logic              wr1_en;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  rd_src_e           rd_src  [NUM_RD];

  // Enables are qualified once here so storage, bypass and scoreboard all agree
  // that nothing is written during reset or to a hard-wired zero register.
  always_comb begin
    wr0_en = rst_n && writ_ena0 && !(ZERO_R0 && (writ_add0 == '0));
    wr1_en = rst_n && writ_ena1 && !(ZERO_R0 && (writ_add1 == '0));
  end

  always_comb begin
    mem_d = mem_q;
    if (wr0_en) mem_d[writ_add0] = writ_dat0;
    if (wr1_en) mem_d[writ_add1] = writ_dat1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = read_add[port_lsb(k, ADDR_W) +: ADDR_W];
      if (ZERO_R0 && (rd_addr[k] == '0))
        rd_src[k] = RD_ZERO;
      else if (wr1_en && (writ_add1 == rd_addr[k]))
        rd_src[k] = RD_BYP1;
      else if (wr0_en && (writ_add0 == rd_addr[k]))
        rd_src[k] = RD_BYP0;
      else
        rd_src[k] = RD_STORE;
    end
  end

  always_comb begin
    read_dat = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      case (rd_src[k])
        RD_STORE: read_dat[port_lsb(k, DATA_W) +: DATA_W] = mem_q[rd_addr[k]];
        RD_BYP0:  read_dat[port_lsb(k, DATA_W) +: DATA_W] = writ_dat0;
        RD_BYP1:  read_dat[port_lsb(k, DATA_W) +: DATA_W] = writ_dat1;
        default:  read_dat[port_lsb(k, DATA_W) +: DATA_W] = '0;
      endcase
    end
  end

  regfile_sb #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr0_en    (wr0_en),
    .wr0_add   (writ_add0),
    .wr1_en    (wr1_en),
    .wr1_add   (writ_add1),
    .resv_vld  (resv_vld),
    .resv_add  (resv_add),
    .read_add  (read_add),
    .resv_rdy  (resv_rdy),
    .read_busy (read_busy),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (A) and a 32-bit, 4-read-port,
// zero-register instance (B) share one stimulus stream against array models.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        writ_ena0, writ_ena1, resv_vld;
  logic [2:0]  writ_add0, writ_add1, resv_add;
  logic [31:0] writ_dat0, writ_dat1;
  logic [11:0] rd_add;

  logic [31:0]  rdat_a;
  logic [1:0]   rbusy_a;
  logic         rdy_a;
  logic [7:0]   busy_a;
  logic [127:0] rdat_b;
  logic [3:0]   rbusy_b;
  logic         rdy_b;
  logic [7:0]   busy_b;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem  [2][8];
  logic [7:0]  m_busy [2];

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .writ_ena0(writ_ena0), .writ_add0(writ_add0), .writ_dat0(writ_dat0[15:0]),
    .writ_ena1(writ_ena1), .writ_add1(writ_add1), .writ_dat1(writ_dat1[15:0]),
    .read_add(rd_add[5:0]), .read_dat(rdat_a), .read_busy(rbusy_a),
    .resv_vld(resv_vld), .resv_add(resv_add), .resv_rdy(rdy_a), .busy_vec(busy_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .ZERO_R0(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .writ_ena0(writ_ena0), .writ_add0(writ_add0), .writ_dat0(writ_dat0),
    .writ_ena1(writ_ena1), .writ_add1(writ_add1), .writ_dat1(writ_dat1),
    .read_add(rd_add), .read_dat(rdat_b), .read_busy(rbusy_b),
    .resv_vld(resv_vld), .resv_add(resv_add), .resv_rdy(rdy_b), .busy_vec(busy_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: inst 0 = A (16-bit), inst 1 = B (32-bit, r0 hard zero)
  function automatic logic [31:0] dmask(input int i, input logic [31:0] d);
    return (i == 0) ? {16'h0, d[15:0]} : d;
  endfunction

  function automatic bit is_zr(input int i, input logic [2:0] a);
    return (i == 1) && (a == 3'd0);
  endfunction

  function automatic bit wok(input int i, input int p);
    if (p == 0) return writ_ena0 && !is_zr(i, writ_add0);
    return writ_ena1 && !is_zr(i, writ_add1);
  endfunction

  function automatic bit wr_to(input int i, input logic [2:0] a);
    return (wok(i, 0) && writ_add0 == a) || (wok(i, 1) && writ_add1 == a);
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input logic [2:0] a);
    if (is_zr(i, a)) return 32'h0;
    if (wok(i, 1) && writ_add1 == a) return dmask(i, writ_dat1);
    if (wok(i, 0) && writ_add0 == a) return dmask(i, writ_dat0);
    return m_mem[i][a];
  endfunction

  function automatic bit exp_rdy(input int i);
    return resv_vld && (is_zr(i, resv_add) || !m_busy[i][resv_add] || wr_to(i, resv_add));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 8'h0;
      for (int r = 0; r < 8; r++) m_mem[i][r] = 32'h0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit r;
      r = exp_rdy(i);
      if (wok(i, 0)) begin m_mem[i][writ_add0] = dmask(i, writ_dat0); m_busy[i][writ_add0] = 1'b0; end
      if (wok(i, 1)) begin m_mem[i][writ_add1] = dmask(i, writ_dat1); m_busy[i][writ_add1] = 1'b0; end
      if (r && !is_zr(i, resv_add)) m_busy[i][resv_add] = 1'b1;
    end
  endtask

  task automatic check_comb();
    logic [2:0] a;
    for (int k = 0; k < 2; k++) begin
      a = rd_add[k*3 +: 3];
      check($sformatf("a_rdat%0d", k), rdat_a[k*16 +: 16], exp_rd(0, a));
      check($sformatf("a_rbusy%0d", k), rbusy_a[k], m_busy[0][a] && !wr_to(0, a));
    end
    for (int k = 0; k < 4; k++) begin
      a = rd_add[k*3 +: 3];
      check($sformatf("b_rdat%0d", k), rdat_b[k*32 +: 32], exp_rd(1, a));
      check($sformatf("b_rbusy%0d", k), rbusy_b[k], m_busy[1][a] && !wr_to(1, a));
    end
    check("a_resv_rdy", rdy_a, exp_rdy(0));
    check("b_resv_rdy", rdy_b, exp_rdy(1));
  endtask

  task automatic pre();
    #1;
    check_comb();
  endtask

  task automatic post();
    @(posedge clk);
    model_edge();
    #1;
    check("a_busy_vec", busy_a, m_busy[0]);
    check("b_busy_vec", busy_b, m_busy[1]);
  endtask

  task automatic idle();
    writ_ena0 = 0; writ_add0 = 0; writ_dat0 = 0;
    writ_ena1 = 0; writ_add1 = 0; writ_dat1 = 0;
    resv_vld = 0; resv_add = 0; rd_add = 0;
  endtask

  task automatic rand_step();
    writ_ena0 = 1'($urandom_range(0, 1));
    writ_add0 = 3'($urandom_range(0, 7));
    writ_dat0 = $urandom;
    writ_ena1 = 1'($urandom_range(0, 1));
    writ_add1 = 3'($urandom_range(0, 7));
    writ_dat1 = $urandom;
    resv_vld  = ($urandom_range(0, 2) != 0);
    resv_add  = 3'($urandom_range(0, 7));
    rd_add    = 12'($urandom);
    pre();
    post();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_rdat"}, rdat_a, 32'h0);
    check({tag, "_b_rdat"}, rdat_b, 128'h0);
    check({tag, "_a_busy"}, busy_a, 8'h0);
    check({tag, "_b_busy"}, busy_b, 8'h0);
    check({tag, "_a_rdy"}, rdy_a, 1'b0);
    check({tag, "_b_rdy"}, rdy_b, 1'b0);
  endtask

  initial begin
    idle();
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_a_busy", busy_a, 8'h0);
    check("rst_b_busy", busy_b, 8'h0);
    pre(); post();

    // write r5 via port 0 with same-cycle bypass, then stored read
    writ_ena0 = 1; writ_add0 = 3'd5; writ_dat0 = 32'h1234; rd_add = 12'd5;
    pre();
    check("bypass_r5", rdat_a[15:0], 16'h1234);
    post();
    idle(); rd_add = 12'd5;
    pre();
    check("stored_r5", rdat_a[15:0], 16'h1234);
    post();

    // both ports hit r3; port 1 must win
    idle();
    writ_ena0 = 1; writ_add0 = 3'd3; writ_dat0 = 32'hAAAA;
    writ_ena1 = 1; writ_add1 = 3'd3; writ_dat1 = 32'h5555;
    pre(); post();
    idle(); rd_add = 12'd3;
    pre();
    check("collide_r3", rdat_a[15:0], 16'h5555);
    post();

    // reservation on r2: accept, refuse, accept alongside a write
    idle(); resv_vld = 1; resv_add = 3'd2;
    pre();
    check("resv_r2_rdy", rdy_a, 1'b1);
    post();
    check("resv_r2_busy", busy_a, 8'h04);
    pre();
    check("resv_r2_again", rdy_a, 1'b0);
    post();
    check("resv_r2_hold", busy_a, 8'h04);
    writ_ena0 = 1; writ_add0 = 3'd2; writ_dat0 = 32'h0F0F;
    pre();
    check("resv_wr_rdy", rdy_a, 1'b1);
    post();
    check("resv_wr_busy", busy_a, 8'h04);
    idle(); rd_add = 12'd2;
    pre();
    check("r2_data", rdat_a[15:0], 16'h0F0F);
    post();

    // hard-wired zero register on instance B
    idle();
    writ_ena0 = 1; writ_add0 = 3'd0; writ_dat0 = 32'hFFFF;
    resv_vld = 1; resv_add = 3'd0; rd_add = 12'd0;
    pre();
    check("zr_rdy", rdy_b, 1'b1);
    check("zr_bypass", rdat_b[31:0], 32'h0);
    post();
    check("zr_busy0", busy_b[0], 1'b0);
    idle();
    pre();
    check("zr_read", rdat_b[31:0], 32'h0);
    post();

    // load r1..r7 then four concurrent reads r1,r2,r1,r7
    for (int r = 1; r < 8; r++) begin
      idle();
      writ_ena1 = 1; writ_add1 = 3'(r); writ_dat1 = 32'hC000_0000 + 32'(r * 32'h111);
      pre(); post();
    end
    idle(); rd_add = {3'd7, 3'd1, 3'd2, 3'd1};
    pre();
    check("mp_p0", rdat_b[31:0],   32'hC000_0111);
    check("mp_p1", rdat_b[63:32],  32'hC000_0222);
    check("mp_p2", rdat_b[95:64],  32'hC000_0111);
    check("mp_p3", rdat_b[127:96], 32'hC000_0777);
    post();

    for (int n = 0; n < 400; n++) rand_step();

    // asynchronous reset in mid-cycle with traffic present
    for (int r = 1; r < 8; r++) begin
      idle();
      writ_ena0 = 1; writ_add0 = 3'(r); writ_dat0 = 32'h0100 + 32'(r);
      pre(); post();
    end
    idle(); resv_vld = 1; resv_add = 3'd6;
    pre(); post();
    rd_add = {3'd7, 3'd6, 3'd5, 3'd1};
    writ_ena0 = 1; writ_add0 = 3'd4; writ_dat0 = 32'hBEEF;
    writ_ena1 = 1; writ_add1 = 3'd6; writ_dat1 = 32'hCAFE;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    check_all_zero("rst_edge");
    #3 rst_n = 1'b1;
    pre(); post();
    rd_add = {3'd7, 3'd6, 3'd4, 3'd1};
    idle(); rd_add = {3'd7, 3'd6, 3'd4, 3'd1};
    pre();
    check("post_rst_r4", rdat_b[63:32], 32'hBEEF);
    check("post_rst_r1", rdat_b[31:0], 32'h0);
    post();

    for (int n = 0; n < 200; n++) rand_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
